// File: rtl/beat_seq_pkg.sv
// Shared constants and state encoding for the beaten-pixel frame sequencer.
package beat_seq_pkg;

  // Mode word layout and ADC sample width shared with the filter datapath.
  localparam int MODE_MAX  = 3;
  localparam int MODE_BEAT = 0;
  localparam int ADC_WIDHT = 12;

  // Sequencer states: waiting for a frame, counting samples, flushing the filter.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } beat_state_e;

endpackage

// File: rtl/beat_seq_pos_cnt.sv
// Sample-pair / line position counter for one sensor frame.
// x wraps at PIX_PAIRS-1 and y at LINES-1; LINE_END is a registered pulse on the
// last sample of a line. x_next exposes the value x will take at the next edge so
// the parent can register ENABLE in step with PIX_X.
module beat_pos_cnt #(
  parameter int PIX_PAIRS = 320,
  parameter int LINES     = 288,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] x_next,
  output logic           line_end,
  output logic           last_sample
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           line_end_q, line_end_d;
  logic           last_x;

  assign last_x = (x_q == X_W'(PIX_PAIRS - 1));

  // Next position: clear wins over advance; wrap x at line end and y at frame end.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    line_end_d = 1'b0;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (last_x) begin
        x_d        = '0;
        line_end_d = 1'b1;
        if (y_q == Y_W'(LINES - 1)) begin
          y_d = '0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      line_end_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      line_end_q <= line_end_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign x_next      = x_d;
  assign line_end    = line_end_q;
  assign last_sample = last_x && (y_q == Y_W'(LINES - 1));

endmodule

// File: rtl/beat_seq.sv
// Frame sequencer for the beaten-pixel filter: tracks frame position, gates the
// filter ENABLE (low for the reference-seeding border of each line), flushes the
// filter pipeline after the last sample, and holds the frame-synchronous threshold.
// STATE_DBG exposes the FSM state for observation.
module beat_seq
  import beat_seq_pkg::*;
#(
  parameter int PIX_PAIRS = 320,
  parameter int LINES     = 288,
  parameter int BORDER    = 1,
  parameter int HOLD      = 4,
  parameter int DEF_LEVEL = 200,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [MODE_MAX:0]    MODE_FPGA,
  input  logic                 FRAME_START,
  input  logic                 SAMPLE_STB,
  input  logic [ADC_WIDHT-1:0] CFG_LEVEL,
  input  logic                 CFG_WE,
  input  logic                 OVR_CLR,
  output logic                 ENABLE,
  output logic [ADC_WIDHT-1:0] BEATEN_PIX_LEVEL,
  output logic [X_W-1:0]       PIX_X,
  output logic [Y_W-1:0]       PIX_Y,
  output logic                 LINE_END,
  output logic                 FRAME_DONE,
  output logic                 OVERRUN,
  output beat_state_e          STATE_DBG
);

  localparam int H_W = $clog2(HOLD + 1);

  beat_state_e          state_q, state_d;
  logic [H_W-1:0]       hold_q, hold_d;
  logic                 enable_q, enable_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;
  logic [ADC_WIDHT-1:0] level_q, level_d;
  logic [ADC_WIDHT-1:0] pend_q, pend_d;
  logic                 pend_flag_q, pend_flag_d;

  logic                 mode_on;
  logic                 mode_unused;
  logic                 cnt_adv;
  logic [X_W-1:0]       x_next;
  logic                 last_sample;

  assign mode_on     = MODE_FPGA[MODE_BEAT];
  assign mode_unused = ^MODE_FPGA;
  // Samples only move the counter while a frame is active; FRAME_START takes priority.
  assign cnt_adv     = (state_q == ST_ACTIVE) && SAMPLE_STB && !FRAME_START;

  beat_pos_cnt #(
    .PIX_PAIRS (PIX_PAIRS),
    .LINES     (LINES),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) u_pos_cnt (
    .clk         (CLK),
    .rst_n       (RST_N),
    .clr         (FRAME_START),
    .adv         (cnt_adv),
    .x           (PIX_X),
    .y           (PIX_Y),
    .x_next      (x_next),
    .line_end    (LINE_END),
    .last_sample (last_sample)
  );

  // FSM next state, flush hold counter, ENABLE and FRAME_DONE.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    enable_d     = 1'b0;
    frame_done_d = 1'b0;
    if (FRAME_START) begin
      // Any FRAME_START (re)starts a frame; an aborted frame gives no FRAME_DONE.
      state_d  = ST_ACTIVE;
      hold_d   = '0;
      enable_d = mode_on && (x_next >= X_W'(BORDER));
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACTIVE: begin
          enable_d = mode_on && (x_next >= X_W'(BORDER));
          if (cnt_adv && last_sample) begin
            state_d  = ST_FLUSH;
            hold_d   = H_W'(HOLD);
            enable_d = mode_on;
          end
        end
        ST_FLUSH: begin
          // ENABLE stays up for HOLD cycles after the last sample, then FRAME_DONE.
          enable_d = mode_on;
          if (hold_q <= H_W'(1)) begin
            state_d      = ST_IDLE;
            hold_d       = '0;
            enable_d     = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Threshold shadow and sticky OVERRUN; a write coincident with FRAME_START stays pending.
  always_comb begin
    level_d     = level_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    overrun_d   = overrun_q;
    if (FRAME_START && pend_flag_q) begin
      level_d     = pend_q;
      pend_flag_d = 1'b0;
    end
    if (CFG_WE) begin
      pend_d      = CFG_LEVEL;
      pend_flag_d = 1'b1;
    end
    if (OVR_CLR) begin
      overrun_d = 1'b0;
    end
    if (FRAME_START && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      level_q      <= ADC_WIDHT'(DEF_LEVEL);
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      level_q      <= level_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
    end
  end

  assign ENABLE           = enable_q;
  assign BEATEN_PIX_LEVEL = level_q;
  assign FRAME_DONE       = frame_done_q;
  assign OVERRUN          = overrun_q;
  assign STATE_DBG        = state_q;

endmodule

// File: tb/tb_beat_seq.sv
// Self-checking bench for beat_seq with a 4x2 frame, BORDER=1, HOLD=4.
module tb_beat_seq;
  import beat_seq_pkg::*;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int LW  = ADC_WIDHT;
  localparam int EW  = 2 + X_W + Y_W;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [MODE_MAX:0] MODE_FPGA;
  logic              FRAME_START, SAMPLE_STB, CFG_WE, OVR_CLR;
  logic [LW-1:0]     CFG_LEVEL;
  logic              ENABLE, LINE_END, FRAME_DONE, OVERRUN;
  logic [LW-1:0]     BEATEN_PIX_LEVEL;
  logic [X_W-1:0]    PIX_X;
  logic [Y_W-1:0]    PIX_Y;
  beat_state_e       STATE_DBG;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           en;
    logic           le;
    logic           chk_y;
  } vec_t;
  vec_t tbl[8];

  logic [EW-1:0] exp_q[$];

  beat_seq #(
    .PIX_PAIRS (4),
    .LINES     (2),
    .BORDER    (1),
    .HOLD      (4),
    .DEF_LEVEL (200),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .MODE_FPGA        (MODE_FPGA),
    .FRAME_START      (FRAME_START),
    .SAMPLE_STB       (SAMPLE_STB),
    .CFG_LEVEL        (CFG_LEVEL),
    .CFG_WE           (CFG_WE),
    .OVR_CLR          (OVR_CLR),
    .ENABLE           (ENABLE),
    .BEATEN_PIX_LEVEL (BEATEN_PIX_LEVEL),
    .PIX_X            (PIX_X),
    .PIX_Y            (PIX_Y),
    .LINE_END         (LINE_END),
    .FRAME_DONE       (FRAME_DONE),
    .OVERRUN          (OVERRUN),
    .STATE_DBG        (STATE_DBG)
  );

  // Clock and global time limit.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame();
    FRAME_START = 1'b1;
    cyc();
    FRAME_START = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    MODE_FPGA            = '0;
    MODE_FPGA[MODE_BEAT] = m;
  endtask

  // Drive eight strobes (5-cycle spacing) from x=0,y=0 and check through FRAME_DONE.
  task automatic run_frame(input logic m, input int cfg_at, input logic [LW-1:0] cfg_val);
    logic [EW-1:0] e;
    int            lat;
    set_mode(m);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({tbl[i].en & m, tbl[i].le, tbl[i].x, tbl[i].y});
      SAMPLE_STB = 1'b1;
      cyc();
      SAMPLE_STB = 1'b0;
      e = exp_q.pop_front();
      chk("enable", ENABLE, e[EW-1]);
      chk("line_end", LINE_END, e[EW-2]);
      chk("pix_x", PIX_X, e[X_W+Y_W-1:Y_W]);
      if (tbl[i].chk_y) chk("pix_y", PIX_Y, e[Y_W-1:0]);
      if (i < 7) begin
        for (int g = 0; g < 4; g++) begin
          if (i == cfg_at && g == 1) begin
            CFG_WE    = 1'b1;
            CFG_LEVEL = cfg_val;
          end
          cyc();
          CFG_WE = 1'b0;
          if (g == 0) chk("line_end_pulse", LINE_END, 0);
          chk("enable_steady", ENABLE, e[EW-1]);
        end
      end
    end
    chk("state_flush", STATE_DBG, ST_FLUSH);
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      cyc();
      if (FRAME_DONE) lat = n;
      else chk("flush_enable", ENABLE, m);
    end
    chk("frame_done_lat", lat, 4);
    chk("enable_after_done", ENABLE, 0);
    chk("state_idle", STATE_DBG, ST_IDLE);
    cyc();
    chk("frame_done_pulse", FRAME_DONE, 0);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{10'd1, 9'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{10'd2, 9'd0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{10'd3, 9'd0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{10'd0, 9'd1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{10'd1, 9'd1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{10'd2, 9'd1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{10'd3, 9'd1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{10'd0, 9'd0, 1'b1, 1'b1, 1'b0};

    set_mode(1'b1);
    FRAME_START = 1'b0;
    SAMPLE_STB  = 1'b0;
    CFG_WE      = 1'b0;
    CFG_LEVEL   = '0;
    OVR_CLR     = 1'b0;
    RST_N       = 1'b0;
    cyc();
    cyc();
    RST_N = 1'b1;
    cyc();

    // Reset values.
    chk("rst_enable", ENABLE, 0);
    chk("rst_level", BEATEN_PIX_LEVEL, 200);
    chk("rst_x", PIX_X, 0);
    chk("rst_y", PIX_Y, 0);
    chk("rst_line_end", LINE_END, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_state", STATE_DBG, ST_IDLE);

    // Full frame.
    start_frame();
    chk("fs_state", STATE_DBG, ST_ACTIVE);
    chk("fs_enable", ENABLE, 0);
    chk("fs_x", PIX_X, 0);
    run_frame(1'b1, -1, '0);
    chk("f1_level", BEATEN_PIX_LEVEL, 200);
    chk("f1_overrun", OVERRUN, 0);

    // Threshold written mid-frame stays shadowed until the next FRAME_START.
    start_frame();
    run_frame(1'b1, 2, 12'h100);
    chk("shadow_hold", BEATEN_PIX_LEVEL, 200);
    start_frame();
    chk("shadow_apply", BEATEN_PIX_LEVEL, 12'h100);
    run_frame(1'b1, -1, '0);

    // Write coincident with FRAME_START stays pending.
    CFG_WE = 1'b1; CFG_LEVEL = 12'h050;
    cyc();
    CFG_WE = 1'b0;
    chk("pend_idle", BEATEN_PIX_LEVEL, 12'h100);
    FRAME_START = 1'b1; CFG_WE = 1'b1; CFG_LEVEL = 12'h070;
    cyc();
    FRAME_START = 1'b0; CFG_WE = 1'b0;
    chk("coinc_level", BEATEN_PIX_LEVEL, 12'h050);
    chk("coinc_no_ovr", OVERRUN, 0);

    // Overrun after five strobes.
    for (int i = 0; i < 5; i++) begin
      SAMPLE_STB = 1'b1;
      cyc();
      SAMPLE_STB = 1'b0;
      repeat (4) cyc();
    end
    chk("pre_ovr_x", PIX_X, 1);
    chk("pre_ovr_y", PIX_Y, 1);
    start_frame();
    chk("ovr_set", OVERRUN, 1);
    chk("ovr_x", PIX_X, 0);
    chk("ovr_y", PIX_Y, 0);
    chk("ovr_level", BEATEN_PIX_LEVEL, 12'h070);
    chk("ovr_state", STATE_DBG, ST_ACTIVE);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (FRAME_DONE) cnt++;
      cyc();
    end
    chk("ovr_no_done", cnt, 0);
    OVR_CLR = 1'b1;
    cyc();
    OVR_CLR = 1'b0;
    chk("ovr_clr", OVERRUN, 0);
    OVR_CLR = 1'b1; FRAME_START = 1'b1;
    cyc();
    OVR_CLR = 1'b0; FRAME_START = 1'b0;
    chk("ovr_set_wins", OVERRUN, 1);
    OVR_CLR = 1'b1;
    cyc();
    OVR_CLR = 1'b0;
    chk("ovr_clr2", OVERRUN, 0);

    // Mode off for a whole frame; same LINE_END / FRAME_DONE timing.
    run_frame(1'b0, -1, '0);
    chk("mode_off_level", BEATEN_PIX_LEVEL, 12'h070);

    // SAMPLE_STB in IDLE is ignored.
    SAMPLE_STB = 1'b1;
    cyc();
    SAMPLE_STB = 1'b0;
    chk("idle_stb_x", PIX_X, 0);
    chk("idle_stb_state", STATE_DBG, ST_IDLE);
    chk("idle_stb_le", LINE_END, 0);

    // Mode bit cleared mid-frame, then reset during FLUSH.
    set_mode(1'b1);
    start_frame();
    SAMPLE_STB = 1'b1;
    cyc();
    SAMPLE_STB = 1'b0;
    chk("mid_en", ENABLE, 1);
    set_mode(1'b0);
    cyc();
    chk("mid_mode_off_en", ENABLE, 0);
    chk("mid_mode_off_x", PIX_X, 1);
    set_mode(1'b1);
    cyc();
    chk("mid_mode_on_en", ENABLE, 1);
    for (int i = 0; i < 7; i++) begin
      repeat (3) cyc();
      SAMPLE_STB = 1'b1;
      cyc();
      SAMPLE_STB = 1'b0;
    end
    chk("rst_pre_state", STATE_DBG, ST_FLUSH);
    cyc();
    cyc();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_enable", ENABLE, 0);
    chk("arst_level", BEATEN_PIX_LEVEL, 200);
    chk("arst_x", PIX_X, 0);
    chk("arst_y", PIX_Y, 0);
    chk("arst_line_end", LINE_END, 0);
    chk("arst_frame_done", FRAME_DONE, 0);
    chk("arst_overrun", OVERRUN, 0);
    chk("arst_state", STATE_DBG, ST_IDLE);
    cyc();
    cyc();
    RST_N = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (FRAME_DONE) cnt++;
    end
    chk("arst_no_done", cnt, 0);
    chk("arst_stay_idle", STATE_DBG, ST_IDLE);
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_seq.md
# beat_seq

Frame sequencer and configuration controller for the beaten-pixel filter stage. Tracks sensor frame position from the frame-start pulse and the per-sample strobe, and drives the filter's ENABLE so its reference value is re-seeded at the start of every line. It flushes the filter's 4-cycle pipeline after the last sample of a frame. It also holds the live BEATEN_PIX_LEVEL threshold, with frame-synchronous shadow update from the control interface. Sits between the sensor timing generator / control registers and the filter, on the filter's CLK domain.

## Interface
- PIX_PAIRS, 320: ADC sample pairs per line
- LINES, 288: lines per frame
- BORDER, 1: sample pairs at the start of each line with ENABLE held low (reference seeding); 1..PIX_PAIRS-1
- HOLD, 4: CLK cycles ENABLE stays high after the last sample of a frame
- DEF_LEVEL, 200: reset value of BEATEN_PIX_LEVEL
- X_W, 10 / Y_W, 9: widths of PIX_X / PIX_Y
- CLK  in  1  filter system clock
- RST_N  in  1  reset, asynchronous, active-low
- MODE_FPGA  in  `MODE_MAX+1  mode word; bit `MODE_BEAT gates filtering
- FRAME_START  in  1  one-CLK pulse, start of frame
- SAMPLE_STB  in  1  one-CLK pulse per ADC sample pair; spacing ≥4 CLK
- CFG_LEVEL  in  `ADC_WIDHT  new threshold
- CFG_WE  in  1  one-CLK write strobe for CFG_LEVEL
- OVR_CLR  in  1  clears OVERRUN
- ENABLE  out  1  to filter ENABLE
- BEATEN_PIX_LEVEL  out  `ADC_WIDHT  to filter threshold
- PIX_X  out  X_W  index of next expected sample pair in line
- PIX_Y  out  Y_W  current line index
- LINE_END  out  1  one-CLK pulse on the last sample of each line
- FRAME_DONE  out  1  one-CLK pulse when flush completes
- OVERRUN  out  1  sticky: FRAME_START arrived before FRAME_DONE

## Operation
- States: IDLE, ACTIVE, FLUSH.
- IDLE: SAMPLE_STB ignored; ENABLE=0. On FRAME_START: x=0, y=0, apply pending threshold, go to ACTIVE.
- ACTIVE: on each SAMPLE_STB, x++.
  - At x=PIX_PAIRS-1: x wraps to 0, LINE_END pulses, y++.
  - On the sample with x=PIX_PAIRS-1 and y=LINES-1: go to FLUSH, load hold counter with HOLD.
- ENABLE in ACTIVE = MODE_FPGA[`MODE_BEAT] AND (x ≥ BORDER), registered.
- FLUSH: ENABLE = mode bit; hold counter decrements each CLK. At 0: FRAME_DONE pulse, ENABLE=0, go to IDLE. SAMPLE_STB ignored.
- FRAME_START in ACTIVE or FLUSH:
  - set OVERRUN
  - abort current frame, with no FRAME_DONE
  - restart as from IDLE, applying the pending threshold
- OVERRUN is set/clear priority: set wins over OVR_CLR in the same cycle.
- Threshold shadow:
  - CFG_WE loads the pending register and sets the pending flag.
  - On an accepted FRAME_START with the flag set: BEATEN_PIX_LEVEL ← pending, flag cleared.
  - CFG_WE coincident with FRAME_START: the previous pending value (if any) is applied; the new value stays pending for the next frame.
- Mode bit cleared mid-frame: ENABLE drops the next CLK; counters keep running.

## Timing
- Reset values: ENABLE=0, BEATEN_PIX_LEVEL=DEF_LEVEL, PIX_X=0, PIX_Y=0, LINE_END=0, FRAME_DONE=0, OVERRUN=0, state IDLE, pending flag 0.
- Outputs are registered. ENABLE, PIX_X, PIX_Y, LINE_END and the state change one CLK after the causing strobe.
- BEATEN_PIX_LEVEL updates one CLK after FRAME_START.
- FRAME_DONE occurs HOLD+1 CLK after the final SAMPLE_STB.
- Async reset mid-frame returns immediately to the reset values; the next frame needs a fresh FRAME_START.

## Structure
- State encoding and the `MODE_BEAT / `ADC_WIDHT / `MODE_MAX constants come from the shared define.v; add beat_seq state localparams there.
- One natural sub-module: beat_pos_cnt (x/y counter with wrap, LINE_END and last-sample flags). FSM, threshold shadow and OVERRUN stay in beat_seq.

## Test plan
Use PIX_PAIRS=4, LINES=2, BORDER=1, HOLD=4, mode bit=1 unless stated.
- Full frame: FRAME_START, then 8 SAMPLE_STB every 5 CLK.
  - ENABLE is 0 for sample pairs x=0 and 1..3 high in each line.
  - LINE_END follows the 4th and 8th strobes.
  - FRAME_DONE fires 5 CLK after the 8th strobe; the block returns to IDLE.
- Threshold shadow: CFG_WE with 0x0100 mid-frame → BEATEN_PIX_LEVEL stays 200 until the next FRAME_START, then reads 0x0100.
- Simultaneous events: CFG_WE 0x0050 pending, then CFG_WE 0x0070 in the same cycle as FRAME_START → level becomes 0x0050; 0x0070 is applied at the following FRAME_START.
- Overrun: FRAME_START after 5 strobes → OVERRUN=1, PIX_X=0, PIX_Y=0, no FRAME_DONE. OVR_CLR then clears OVERRUN; OVR_CLR in the same cycle as a new overrun leaves OVERRUN=1.
- Mode off: mode bit 0 for a whole frame → ENABLE is never 1, LINE_END/FRAME_DONE timing is unchanged, and SAMPLE_STB in IDLE does not move PIX_X.
- Reset: RST_N low during FLUSH → all outputs return to their reset values asynchronously, and no FRAME_DONE is issued.
